// File: rtl/axi_line_fill_master_if.sv
// rtl/axi_line_fill_master_if.sv - line request/response and AXI4 read-channel bundle
interface axi_line_fill_master_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 8,
    parameter int BEATS      = 8
);
    logic                          req_valid;
    logic                          req_ready;
    logic [ADDR_WIDTH-1:0]         req_addr;
    logic                          resp_valid;
    logic                          resp_ready;
    logic [BEATS*DATA_WIDTH-1:0]   resp_data;
    logic                          resp_error;

    logic                          m_axi_arvalid;
    logic                          m_axi_arready;
    logic [ID_WIDTH-1:0]           m_axi_arid;
    logic [ADDR_WIDTH-1:0]         m_axi_araddr;
    logic [7:0]                    m_axi_arlen;
    logic [2:0]                    m_axi_arsize;
    logic [1:0]                    m_axi_arburst;
    logic                          m_axi_rvalid;
    logic                          m_axi_rready;
    logic [ID_WIDTH-1:0]           m_axi_rid;
    logic [DATA_WIDTH-1:0]         m_axi_rdata;
    logic [1:0]                    m_axi_rresp;
    logic                          m_axi_rlast;

    modport master (
        input  req_valid, req_addr, resp_ready,
        output req_ready, resp_valid, resp_data, resp_error,
        output m_axi_arvalid, m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
        input  m_axi_arready,
        input  m_axi_rvalid, m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast,
        output m_axi_rready
    );

    modport slave (
        output req_valid, req_addr, resp_ready,
        input  req_ready, resp_valid, resp_data, resp_error,
        input  m_axi_arvalid, m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
        output m_axi_arready,
        output m_axi_rvalid, m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast,
        input  m_axi_rready
    );
endinterface

// File: rtl/axi_line_fill_master.sv
// rtl/axi_line_fill_master.sv - AXI4 read-burst initiator assembling one cache line per request
module axi_line_fill_master #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 8,
    parameter int ARID       = 0,
    parameter int BEATS      = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    axi_line_fill_master_if.master bus
);
    localparam int LINE_W = BEATS * DATA_WIDTH;
    localparam int OFF_W  = $clog2(BEATS * DATA_WIDTH / 8);
    localparam int CNT_W  = $clog2(BEATS) + 1;

    localparam logic [ADDR_WIDTH-1:0] LINE_MASK = {ADDR_WIDTH{1'b1}} << OFF_W;
    localparam logic [CNT_W-1:0]      CNT_MAX   = CNT_W'(BEATS);
    localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'(BEATS - 1);
    localparam logic [ID_WIDTH-1:0]   ID_V      = ID_WIDTH'(ARID);

    typedef enum logic [1:0] {S_IDLE, S_AR, S_DATA, S_RESP} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   araddr_q, araddr_d;
    logic                    arvalid_q, arvalid_d;
    logic                    rready_q, rready_d;
    logic                    resp_valid_q, resp_valid_d;
    logic                    err_q, err_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [LINE_W-1:0]       line_q, line_d;
    logic                    beat_err;

    always_comb begin
        state_d      = state_q;
        araddr_d     = araddr_q;
        arvalid_d    = arvalid_q;
        rready_d     = rready_q;
        resp_valid_d = resp_valid_q;
        err_d        = err_q;
        cnt_d        = cnt_q;
        line_d       = line_q;
        beat_err     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    araddr_d  = bus.req_addr & LINE_MASK;
                    cnt_d     = '0;
                    err_d     = 1'b0;
                    arvalid_d = 1'b1;
                    state_d   = S_AR;
                end
            end
            S_AR: begin
                if (bus.m_axi_arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = S_DATA;
                end
            end
            S_DATA: begin
                if (bus.m_axi_rvalid) begin
                    // Beats past the line length are dropped and flag the burst as faulty.
                    for (int k = 0; k < BEATS; k++) begin
                        if (cnt_q == CNT_W'(k)) begin
                            line_d[k*DATA_WIDTH +: DATA_WIDTH] = bus.m_axi_rdata;
                        end
                    end
                    if (cnt_q >= CNT_MAX)                         beat_err = 1'b1;
                    if (bus.m_axi_rresp[1])                       beat_err = 1'b1;
                    if (bus.m_axi_rid != ID_V)                    beat_err = 1'b1;
                    if (bus.m_axi_rlast && (cnt_q != CNT_LAST))   beat_err = 1'b1;
                    err_d = err_q | beat_err;
                    if (cnt_q < CNT_MAX) cnt_d = cnt_q + 1'b1;
                    if (bus.m_axi_rlast) begin
                        rready_d     = 1'b0;
                        resp_valid_d = 1'b1;
                        state_d      = S_RESP;
                    end
                end
            end
            S_RESP: begin
                if (bus.resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            araddr_q     <= '0;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            resp_valid_q <= 1'b0;
            err_q        <= 1'b0;
            cnt_q        <= '0;
            line_q       <= '0;
        end else begin
            state_q      <= state_d;
            araddr_q     <= araddr_d;
            arvalid_q    <= arvalid_d;
            rready_q     <= rready_d;
            resp_valid_q <= resp_valid_d;
            err_q        <= err_d;
            cnt_q        <= cnt_d;
            line_q       <= line_d;
        end
    end

    assign bus.req_ready     = (state_q == S_IDLE);
    assign bus.resp_valid    = resp_valid_q;
    assign bus.resp_data     = line_q;
    assign bus.resp_error    = err_q;
    assign bus.m_axi_arvalid = arvalid_q;
    assign bus.m_axi_arid    = ID_V;
    assign bus.m_axi_araddr  = araddr_q;
    assign bus.m_axi_arlen   = 8'(BEATS - 1);
    assign bus.m_axi_arsize  = 3'($clog2(DATA_WIDTH / 8));
    assign bus.m_axi_arburst = 2'b01;
    assign bus.m_axi_rready  = rready_q;
endmodule
